// File: rtl/mem_port_arbiter.sv
// Arbitrates a single data-memory port between the core MEM stage and an external loader/debug port.
// Optional starvation guard enabled by defining ARB_STARVE_GUARD_EN.
module mem_port_arbiter #(
  parameter int DM_ADDRESS   = 9,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  core_rd,
  input  logic                  core_wr,
  input  logic [DM_ADDRESS-1:0] core_addr,
  input  logic [DATA_W-1:0]     core_wdata,
  input  logic [2:0]            core_funct3,
  output logic [DATA_W-1:0]     core_rdata,
  output logic                  core_stall,
  input  logic                  ext_valid,
  input  logic                  ext_we,
  input  logic [DM_ADDRESS-1:0] ext_addr,
  input  logic [DATA_W-1:0]     ext_wdata,
  output logic                  ext_ready,
  output logic [DATA_W-1:0]     ext_rdata,
  output logic                  ext_rvalid,
  output logic                  mem_rd,
  output logic                  mem_wr,
  output logic [DM_ADDRESS-1:0] mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic [2:0]            mem_funct3,
  input  logic [DATA_W-1:0]     mem_rdata
);

  if (STARVE_LIMIT < 1) begin : g_bad_limit
    $error("STARVE_LIMIT must be at least 1");
  end

  logic core_req;
  logic core_grant;
  logic ext_grant;
  logic stall;

  assign core_req = core_rd | core_wr;

`ifdef ARB_STARVE_GUARD_EN
  typedef enum logic {NORMAL, FORCE} state_t;

  localparam int CNT_W = $clog2(STARVE_LIMIT) + 1;
  localparam logic [CNT_W-1:0] CNT_TRIP = CNT_W'(STARVE_LIMIT - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] wait_cnt, wait_cnt_nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= NORMAL;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    core_grant   = 1'b0;
    ext_grant    = 1'b0;
    stall        = 1'b0;
    case (state)
      NORMAL: begin
        if (core_req) begin
          core_grant = 1'b1;
          if (ext_valid) begin
            wait_cnt_nxt = wait_cnt + 1'b1;
            if (wait_cnt == CNT_TRIP) state_nxt = FORCE;
          end else begin
            wait_cnt_nxt = '0;
          end
        end else begin
          ext_grant    = ext_valid;
          wait_cnt_nxt = '0;
        end
      end
      FORCE: begin
        // Forced slot: ext takes the port and the core is frozen for this one cycle.
        state_nxt    = NORMAL;
        wait_cnt_nxt = '0;
        if (ext_valid) begin
          ext_grant = 1'b1;
          stall     = 1'b1;
        end
      end
      default: begin
        state_nxt    = NORMAL;
        wait_cnt_nxt = '0;
      end
    endcase
  end
`else
  always_comb begin
    core_grant = core_req;
    ext_grant  = ~core_req & ext_valid;
    stall      = 1'b0;
  end
`endif

  always_comb begin
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    mem_funct3 = 3'b000;
    if (core_grant) begin
      mem_rd     = core_rd;
      mem_wr     = core_wr;
      mem_addr   = core_addr;
      mem_wdata  = core_wdata;
      mem_funct3 = core_funct3;
    end else if (ext_grant) begin
      mem_rd     = ~ext_we;
      mem_wr     = ext_we;
      mem_addr   = ext_addr;
      mem_wdata  = ext_wdata;
      mem_funct3 = 3'b010;
    end
  end

  assign core_rdata = mem_rdata;
  assign core_stall = stall;
  assign ext_ready  = ext_grant;

  // p0 -> p1: capture ext read data one cycle after acceptance
  logic              vld_p0;
  logic              vld_p1;
  logic [DATA_W-1:0] ext_rdata_p1;

  assign vld_p0 = ext_grant & ~ext_we;

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p1       <= 1'b0;
      ext_rdata_p1 <= '0;
    end else begin
      vld_p1 <= vld_p0;
      if (vld_p0) ext_rdata_p1 <= mem_rdata;
    end
  end

  assign ext_rvalid = vld_p1;
  assign ext_rdata  = ext_rdata_p1;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural data memory behind the port.
module tb_mem_port_arbiter;
  localparam int AW = 9;
  localparam int DW = 32;
  localparam int SL = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          core_rd, core_wr;
  logic [AW-1:0] core_addr;
  logic [DW-1:0] core_wdata;
  logic [2:0]    core_funct3;
  logic [DW-1:0] core_rdata;
  logic          core_stall;
  logic          ext_valid, ext_we;
  logic [AW-1:0] ext_addr;
  logic [DW-1:0] ext_wdata;
  logic          ext_ready;
  logic [DW-1:0] ext_rdata;
  logic          ext_rvalid;
  logic          mem_rd, mem_wr;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [2:0]    mem_funct3;
  logic [DW-1:0] mem_rdata;

  logic [DW-1:0] mem [0:(1<<AW)-1];

  int n_chk  = 0;
  int n_pass = 0;

  mem_port_arbiter #(.DM_ADDRESS(AW), .DATA_W(DW), .STARVE_LIMIT(SL)) dut (
    .clk(clk), .reset(reset),
    .core_rd(core_rd), .core_wr(core_wr), .core_addr(core_addr),
    .core_wdata(core_wdata), .core_funct3(core_funct3),
    .core_rdata(core_rdata), .core_stall(core_stall),
    .ext_valid(ext_valid), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
    .ext_ready(ext_ready), .ext_rdata(ext_rdata), .ext_rvalid(ext_rvalid),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_funct3(mem_funct3), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) if (mem_wr) mem[mem_addr] <= mem_wdata;

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < (1<<AW); i++) mem[i] = 32'h0;
    mem[9'h010] = 32'h1234_5678;
    mem[9'h040] = 32'hCAFE_F00D;
    reset = 1'b1;
    core_rd = 0; core_wr = 0; core_addr = '0; core_wdata = '0; core_funct3 = 3'b000;
    ext_valid = 0; ext_we = 0; ext_addr = '0; ext_wdata = '0;
    tick(); tick();
    settle();
    chk("rst_rvalid", DW'(ext_rvalid), 0);
    chk("rst_rdata",  ext_rdata, 0);
    chk("rst_stall",  DW'(core_stall), 0);
    chk("rst_memrw",  DW'({mem_rd, mem_wr}), 0);
    chk("rst_addr",   DW'(mem_addr), 0);
    tick();
    reset = 1'b0;

    // Core load word alone
    core_rd = 1; core_addr = 9'h010; core_funct3 = 3'b010;
    settle();
    chk("lw_mem_rd",  DW'(mem_rd), 1);
    chk("lw_addr",    DW'(mem_addr), 32'h010);
    chk("lw_rdata",   core_rdata, 32'h1234_5678);
    chk("lw_f3",      DW'(mem_funct3), 3'b010);
    chk("lw_ready",   DW'(ext_ready), 0);
    chk("lw_stall",   DW'(core_stall), 0);
    tick();

    // Core store byte
    core_rd = 0; core_wr = 1; core_addr = 9'h011; core_wdata = 32'hA5A5_0F0F; core_funct3 = 3'b000;
    settle();
    chk("sb_mem_wr",  DW'({mem_rd, mem_wr}), 1);
    chk("sb_wdata",   mem_wdata, 32'hA5A5_0F0F);
    chk("sb_f3",      DW'(mem_funct3), 0);
    tick();

    // Nobody requests: port parked at zero
    core_wr = 0;
    settle();
    chk("idle_memrw", DW'({mem_rd, mem_wr}), 0);
    chk("idle_addr",  DW'(mem_addr), 0);
    chk("idle_wdata", mem_wdata, 0);
    chk("idle_f3",    DW'(mem_funct3), 0);
    tick();

    // External write then read back
    ext_valid = 1; ext_we = 1; ext_addr = 9'h020; ext_wdata = 32'hDEAD_BEEF;
    settle();
    chk("ew_ready",   DW'(ext_ready), 1);
    chk("ew_memrw",   DW'({mem_rd, mem_wr}), 1);
    chk("ew_f3",      DW'(mem_funct3), 3'b010);
    chk("ew_addr",    DW'(mem_addr), 32'h020);
    chk("ew_wdata",   mem_wdata, 32'hDEAD_BEEF);
    tick();
    ext_we = 0;
    settle();
    chk("er_ready",   DW'(ext_ready), 1);
    chk("er_memrw",   DW'({mem_rd, mem_wr}), 2);
    chk("er_norv",    DW'(ext_rvalid), 0);
    tick();
    ext_valid = 0;
    settle();
    chk("er_rvalid",  DW'(ext_rvalid), 1);
    chk("er_rdata",   ext_rdata, 32'hDEAD_BEEF);
    tick();
    settle();
    chk("er_rv_pulse", DW'(ext_rvalid), 0);
    chk("er_hold",    ext_rdata, 32'hDEAD_BEEF);
    tick();

    // Core holds the port while ext waits
    core_rd = 1; core_addr = 9'h010; core_funct3 = 3'b010;
    ext_valid = 1; ext_we = 0; ext_addr = 9'h020;
`ifdef ARB_STARVE_GUARD_EN
    for (int c = 0; c < SL; c++) begin
      settle();
      chk($sformatf("wait_ready_c%0d", c), DW'(ext_ready), 0);
      chk($sformatf("wait_stall_c%0d", c), DW'(core_stall), 0);
      tick();
    end
    settle();
    chk("force_ready", DW'(ext_ready), 1);
    chk("force_stall", DW'(core_stall), 1);
    chk("force_addr",  DW'(mem_addr), 32'h020);
    chk("force_memrw", DW'({mem_rd, mem_wr}), 2);
    tick();
    ext_valid = 0;
    settle();
    chk("post_addr",   DW'(mem_addr), 32'h010);
    chk("post_stall",  DW'(core_stall), 0);
    chk("post_ready",  DW'(ext_ready), 0);
    chk("post_rvalid", DW'(ext_rvalid), 1);
    chk("post_rdata",  ext_rdata, 32'hDEAD_BEEF);
    tick();

    // Requester abandons the forced slot
    ext_valid = 1;
    for (int c = 0; c < SL; c++) tick();
    ext_valid = 0;
    settle();
    chk("abort_stall", DW'(core_stall), 0);
    chk("abort_memrw", DW'({mem_rd, mem_wr}), 0);
    chk("abort_ready", DW'(ext_ready), 0);
    tick();
    settle();
    chk("abort_next_rd",    DW'(mem_rd), 1);
    chk("abort_next_stall", DW'(core_stall), 0);
    tick();
    core_rd = 0;
`else
    for (int c = 0; c < 20; c++) begin
      settle();
      chk($sformatf("wait_ready_c%0d", c), DW'(ext_ready), 0);
      chk($sformatf("wait_stall_c%0d", c), DW'(core_stall), 0);
      chk($sformatf("wait_addr_c%0d", c),  DW'(mem_addr), 32'h010);
      tick();
    end
    core_rd = 0;
    settle();
    chk("drop_ready", DW'(ext_ready), 1);
    chk("drop_addr",  DW'(mem_addr), 32'h020);
    tick();
    ext_valid = 0;
    settle();
    chk("drop_rvalid", DW'(ext_rvalid), 1);
    chk("drop_rdata",  ext_rdata, 32'hDEAD_BEEF);
    tick();
`endif

    // Read accepted while reset is asserted at the capturing edge is dropped
    ext_valid = 1; ext_we = 0; ext_addr = 9'h040;
    reset = 1;
    settle();
    chk("rr_ready", DW'(ext_ready), 1);
    chk("rr_stall", DW'(core_stall), 0);
    tick();
    ext_valid = 0;
    settle();
    chk("rr_rv_n1",  DW'(ext_rvalid), 0);
    chk("rr_rdata",  ext_rdata, 0);
    tick();
    reset = 0;
    settle();
    chk("rr_rv_n2",  DW'(ext_rvalid), 0);
    chk("rr_stall2", DW'(core_stall), 0);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
